// File: rtl/noc_routing_pkg.sv
// Purpose: shared NoC routing types: output-port encoding and the XY route function.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
// Contents: port_e (router output-port encoding), COORD_WIDTH default, xy_route().
package noc_routing_pkg;

  // Default width of one mesh coordinate. xy_route operates on this width.
  localparam int COORD_WIDTH = 4;

  typedef enum logic [2:0] {
    LOCAL = 3'd0,
    NORTH = 3'd1,
    SOUTH = 3'd2,
    EAST  = 3'd3,
    WEST  = 3'd4
  } port_e;

  // Dimension-ordered routing: the X offset is resolved completely before Y
  // is considered. This keeps the mesh deadlock-free. Coordinates are
  // unsigned, and Y grows toward SOUTH.
  function automatic port_e xy_route(
    input logic [COORD_WIDTH-1:0] dx,
    input logic [COORD_WIDTH-1:0] dy,
    input logic [COORD_WIDTH-1:0] rx,
    input logic [COORD_WIDTH-1:0] ry
  );
    port_e p;
    if (dx > rx)      p = EAST;
    else if (dx < rx) p = WEST;
    else if (dy > ry) p = SOUTH;
    else if (dy < ry) p = NORTH;
    else              p = LOCAL;
    return p;
  endfunction

endpackage

// File: rtl/axis_if.sv
// Purpose: AXI-Stream bundle used between NoC router stages.
// Latency: n/a (wires only).
// Backpressure: standard TVALID/TREADY handshake, with TREADY driven by the sink.
// Ports: TVALID, TREADY, TDATA and TLAST are always present.
//        TSTRB, TKEEP, TID, TDEST and TUSER are present only under their *_PRESENT defines.
//        Modport m is the source side and modport s is the sink side.
interface axis_if #(
  parameter int DATA_WIDTH = 40
`ifdef TID_PRESENT
  , parameter int ID_WIDTH = 4
`endif
`ifdef TDEST_PRESENT
  , parameter int DEST_WIDTH = 4
`endif
`ifdef TUSER_PRESENT
  , parameter int USER_WIDTH = 4
`endif
);
  logic                  TVALID;
  logic                  TREADY;
  logic [DATA_WIDTH-1:0] TDATA;
  logic                  TLAST;
`ifdef TSTRB_PRESENT
  logic [DATA_WIDTH/8-1:0] TSTRB;
`endif
`ifdef TKEEP_PRESENT
  logic [DATA_WIDTH/8-1:0] TKEEP;
`endif
`ifdef TID_PRESENT
  logic [ID_WIDTH-1:0]     TID;
`endif
`ifdef TDEST_PRESENT
  logic [DEST_WIDTH-1:0]   TDEST;
`endif
`ifdef TUSER_PRESENT
  logic [USER_WIDTH-1:0]   TUSER;
`endif

  modport m (
    output TVALID, output TDATA, output TLAST
`ifdef TSTRB_PRESENT
    , output TSTRB
`endif
`ifdef TKEEP_PRESENT
    , output TKEEP
`endif
`ifdef TID_PRESENT
    , output TID
`endif
`ifdef TDEST_PRESENT
    , output TDEST
`endif
`ifdef TUSER_PRESENT
    , output TUSER
`endif
    , input TREADY
  );

  modport s (
    input TVALID, input TDATA, input TLAST
`ifdef TSTRB_PRESENT
    , input TSTRB
`endif
`ifdef TKEEP_PRESENT
    , input TKEEP
`endif
`ifdef TID_PRESENT
    , input TID
`endif
`ifdef TDEST_PRESENT
    , input TDEST
`endif
`ifdef TUSER_PRESENT
    , input TUSER
`endif
    , output TREADY
  );

endinterface

// File: rtl/axis_reg_slice.sv
// Purpose: generic two-entry AXI-Stream skid buffer (output register + skid register).
// Latency: 1 cycle from input handshake to out.TVALID when empty; 1 beat/cycle sustained.
// Backpressure: in.TREADY is a registered !skid_full; it drops the cycle after the skid fills.
// Ports: ACLK, ARESETn (async, active-low); in (sink side), out (source side);
//        load_vld/load_dat/load_last: strobe and content of the beat entering the output register.
module axis_reg_slice #(
  parameter int DATA_WIDTH = 40
`ifdef TID_PRESENT
  , parameter int ID_WIDTH = 4
`endif
`ifdef TDEST_PRESENT
  , parameter int DEST_WIDTH = 4
`endif
`ifdef TUSER_PRESENT
  , parameter int USER_WIDTH = 4
`endif
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  axis_if.s                     in,
  axis_if.m                     out,
  output logic                  load_vld,
  output logic [DATA_WIDTH-1:0] load_dat,
  output logic                  load_last
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0]   data;
`ifdef TSTRB_PRESENT
    logic [DATA_WIDTH/8-1:0] strb;
`endif
`ifdef TKEEP_PRESENT
    logic [DATA_WIDTH/8-1:0] keep;
`endif
`ifdef TID_PRESENT
    logic [ID_WIDTH-1:0]     id;
`endif
`ifdef TDEST_PRESENT
    logic [DEST_WIDTH-1:0]   dest;
`endif
`ifdef TUSER_PRESENT
    logic [USER_WIDTH-1:0]   user;
`endif
    logic                    last;
  } beat_t;

  beat_t in_beat, load_beat, out_q, skid_q;
  logic  out_vld_q, skid_full_q, in_rdy_q;
  logic  accept, consume, out_free, skid_load, skid_full_d;

  always_comb begin
    in_beat      = '0;
    in_beat.data = in.TDATA;
`ifdef TSTRB_PRESENT
    in_beat.strb = in.TSTRB;
`endif
`ifdef TKEEP_PRESENT
    in_beat.keep = in.TKEEP;
`endif
`ifdef TID_PRESENT
    in_beat.id   = in.TID;
`endif
`ifdef TDEST_PRESENT
    in_beat.dest = in.TDEST;
`endif
`ifdef TUSER_PRESENT
    in_beat.user = in.TUSER;
`endif
    in_beat.last = in.TLAST;
  end

  assign accept   = in.TVALID && in_rdy_q;
  assign consume  = out_vld_q && out.TREADY;
  assign out_free = !out_vld_q || consume;

  // The skid entry is older than anything arriving now, so it always wins
  // the output register. This preserves beat order.
  assign load_vld  = out_free && (skid_full_q || accept);
  assign load_beat = skid_full_q ? skid_q : in_beat;
  assign load_dat  = load_beat.data;
  assign load_last = load_beat.last;

  // An accepted beat parks in the skid when the output register cannot take
  // it, or when the output register is taking the previous skid entry.
  assign skid_load = accept && (!out_free || skid_full_q);

  always_comb begin
    skid_full_d = skid_full_q;
    if (skid_load)                    skid_full_d = 1'b1;
    else if (skid_full_q && out_free) skid_full_d = 1'b0;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      out_vld_q   <= 1'b0;
      out_q       <= '0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      in_rdy_q    <= 1'b0;
    end else begin
      if (load_vld) begin
        out_vld_q <= 1'b1;
        out_q     <= load_beat;
      end else if (consume) begin
        out_vld_q <= 1'b0;
      end
      if (skid_load) skid_q <= in_beat;
      skid_full_q <= skid_full_d;
      // Registered from the next-state value. TREADY is then low in exactly
      // the cycles where the skid holds a beat, so the skid never overflows.
      in_rdy_q    <= !skid_full_d;
    end
  end

  assign in.TREADY  = in_rdy_q;
  assign out.TVALID = out_vld_q;
  assign out.TDATA  = out_q.data;
  assign out.TLAST  = out_q.last;
`ifdef TSTRB_PRESENT
  assign out.TSTRB  = out_q.strb;
`endif
`ifdef TKEEP_PRESENT
  assign out.TKEEP  = out_q.keep;
`endif
`ifdef TID_PRESENT
  assign out.TID    = out_q.id;
`endif
`ifdef TDEST_PRESENT
  assign out.TDEST  = out_q.dest;
`endif
`ifdef TUSER_PRESENT
  assign out.TUSER  = out_q.user;
`endif

endmodule

// File: rtl/axis_route_stage.sv
// Purpose: registered XY routing stage ahead of the router output demux; latches ctrl per packet.
// Latency: 1 cycle from input handshake to out.TVALID when empty; 1 beat/cycle sustained.
// Backpressure: two-entry skid; in.TREADY is registered and drops the cycle after the skid fills.
// Ports: ACLK, ARESETn (async, active-low); in: upstream stream; out: stream to the demux;
//        ctrl: output-port select for the beat on out; en: qualifier equal to out.TVALID.
module axis_route_stage #(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER),
  parameter int AXIS_DATA_WIDTH      = 40,
  parameter int COORD_WIDTH          = noc_routing_pkg::COORD_WIDTH,
  parameter logic [COORD_WIDTH-1:0] ROUTER_X = '0,
  parameter logic [COORD_WIDTH-1:0] ROUTER_Y = '0
`ifdef TID_PRESENT
  , parameter int ID_WIDTH = 4
`endif
`ifdef TDEST_PRESENT
  , parameter int DEST_WIDTH = 4
`endif
`ifdef TUSER_PRESENT
  , parameter int USER_WIDTH = 4
`endif
) (
  input  logic                            ACLK,
  input  logic                            ARESETn,
  axis_if.s                               in,
  axis_if.m                               out,
  output logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl,
  output logic                            en
);

  import noc_routing_pkg::*;

  logic                       load_vld;
  logic [AXIS_DATA_WIDTH-1:0] load_dat;
  logic                       load_last;
  logic [COORD_WIDTH-1:0]     dst_x, dst_y;
  port_e                      route;
  logic                       hdr_next;
  logic [CHANNEL_NUMBER_WIDTH-1:0] ctrl_q;
  logic                       unused_payload;

  axis_reg_slice #(
    .DATA_WIDTH (AXIS_DATA_WIDTH)
`ifdef TID_PRESENT
    , .ID_WIDTH (ID_WIDTH)
`endif
`ifdef TDEST_PRESENT
    , .DEST_WIDTH (DEST_WIDTH)
`endif
`ifdef TUSER_PRESENT
    , .USER_WIDTH (USER_WIDTH)
`endif
  ) u_slice (
    .ACLK      (ACLK),
    .ARESETn   (ARESETn),
    .in        (in),
    .out       (out),
    .load_vld  (load_vld),
    .load_dat  (load_dat),
    .load_last (load_last)
  );

  // Only the destination field of a header is interpreted. The rest of the
  // beat is payload.
  assign dst_x          = load_dat[COORD_WIDTH-1:0];
  assign dst_y          = load_dat[2*COORD_WIDTH-1:COORD_WIDTH];
  assign unused_payload = ^load_dat[AXIS_DATA_WIDTH-1:2*COORD_WIDTH];
  assign route          = xy_route(dst_x, dst_y, ROUTER_X, ROUTER_Y);

  // The route is taken from the beat that enters the output register, not
  // from the beat on the input. ctrl therefore moves together with the
  // header in the same cycle, including when a tail leaves and the next
  // header arrives at once.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      hdr_next <= 1'b1;
      ctrl_q   <= '0;
    end else if (load_vld) begin
      if (hdr_next) ctrl_q <= CHANNEL_NUMBER_WIDTH'(route);
      hdr_next <= load_last;
    end
  end

  assign ctrl = ctrl_q;
  assign en   = out.TVALID;

endmodule
